// File: rtl/sa_pkg.sv
// Shared types for the systolic-array support blocks: drain FSM state and psum word type.
package sa_pkg;

    parameter int unsigned PSUM_DW_DEFAULT = 8;

    typedef logic [PSUM_DW_DEFAULT*2-1:0] psum_t;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StShift,
        StDone
    } drain_state_t;

endpackage

// File: rtl/sa_ofmap_drain.sv
// Unloads a finished tile from the systolic array one column at a time and writes each
// column word to the ofmap buffer over a valid/ready port.
module sa_ofmap_drain
    import sa_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned S_WIDTH    = 2,
    parameter int unsigned S_HEIGHT   = 2,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic                                   i_start,
    input  logic [ADDR_WIDTH-1:0]                  i_base_addr,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_psum_out_en,
    input  logic [0:S_HEIGHT-1][DATA_WIDTH*2-1:0]  i_ofmap,
    output logic                                   o_wr_valid,
    input  logic                                   i_wr_ready,
    output logic [ADDR_WIDTH-1:0]                  o_wr_addr,
    output logic [0:S_HEIGHT-1][DATA_WIDTH*2-1:0]  o_wr_data
);

    localparam int unsigned ColWidth  = (S_WIDTH > 1) ? $clog2(S_WIDTH) : 1;
    localparam int unsigned PsumWidth = DATA_WIDTH * 2;
    localparam logic [ColWidth-1:0] LastCol = ColWidth'(S_WIDTH - 1);

    drain_state_t state_q, state_d;
    logic [ColWidth-1:0]                  col_q, col_d;
    logic [ADDR_WIDTH-1:0]                base_q, base_d;
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [0:S_HEIGHT-1][PsumWidth-1:0]   data_q, data_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            col_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (i_start) state_d = StRead;
            StRead:  state_d = StWrite;
            StWrite: begin
                if (i_wr_ready) state_d = (col_q == LastCol) ? StDone : StShift;
            end
            StShift: state_d = StRead;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Column counter, address adder and capture register; address wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        col_d  = col_q;
        base_d = base_q;
        addr_d = addr_q;
        data_d = data_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    base_d = i_base_addr;
                    col_d  = '0;
                end
            end
            StRead: begin
                addr_d = base_q + ADDR_WIDTH'(col_q);
                data_d = i_ofmap;
            end
            StShift: col_d = col_q + ColWidth'(1);
            default: ;
        endcase
    end

    always_comb begin
        o_busy        = (state_q != StIdle);
        o_done        = (state_q == StDone);
        o_psum_out_en = (state_q == StShift);
        o_wr_valid    = (state_q == StWrite);
        o_wr_addr     = addr_q;
        o_wr_data     = data_q;
    end

endmodule
